// File: rtl/recapture_align_if.sv
// Bundle of the recapture/deskew data path and training control signals.
// The master side drives raw lanes and training requests, the slave side
// (the aligner) returns deskewed lanes, programmed skews and status.
interface recapture_align_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int MAX_SKEW = 3
) ();
   localparam int SKEW_W = (MAX_SKEW > 0) ? $clog2(MAX_SKEW + 1) : 1;

   logic [CHANNELS*WIDTH-1:0]  din;
   logic                       din_valid;
   logic                       train_start;
   logic [CHANNELS*WIDTH-1:0]  dout;
   logic                       dout_valid;
   logic [CHANNELS*SKEW_W-1:0] skew;
   logic                       train_busy;
   logic                       aligned;
   logic                       train_fail;

   modport master (
      output din, din_valid, train_start,
      input  dout, dout_valid, skew, train_busy, aligned, train_fail
   );

   modport slave (
      input  din, din_valid, train_start,
      output dout, dout_valid, skew, train_busy, aligned, train_fail
   );
endinterface

// File: rtl/recapture_align.sv
// Multi-lane recapture pipeline with per-lane programmable deskew.
// Each lane passes STAGES fixed registers (first one IOB-packable), then a
// tapped delay line of MAX_SKEW registers; the tap is chosen by the lane's
// skew. A training FSM measures marker arrival spread across lanes, programs
// skews so the latest lane gets zero, then verifies LOCK_COUNT aligned markers.
// MAX_SKEW must be at least 1.
module recapture_align #(
   parameter int               WIDTH         = 8,
   parameter int               CHANNELS      = 4,
   parameter int               STAGES        = 2,
   parameter int               MAX_SKEW      = 3,
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = 8'hA5,
   parameter int               LOCK_COUNT    = 16,
   parameter int               TIMEOUT       = 1024
) (
   input  logic            clk,
   input  logic            reset,
   recapture_align_if.slave bus
);
   localparam int SKEW_W  = (MAX_SKEW > 0) ? $clog2(MAX_SKEW + 1) : 1;
   localparam int T_W     = SKEW_W + 1;
   localparam int TIMER_W = $clog2(TIMEOUT + 1);
   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int FLUSH   = STAGES + MAX_SKEW;
   localparam int FLUSH_W = $clog2(FLUSH + 1);

   localparam logic [T_W-1:0]     T_LIMIT    = T_W'(MAX_SKEW);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SEARCH, ST_VERIFY, ST_DONE, ST_FAIL
   } state_t;

   // Valid is identical for all lanes, so one shared pipeline and one shared
   // history line carry it; each lane picks the tap matching its data tap.
   logic [STAGES-1:0]   pv_q, pv_d;
   logic [MAX_SKEW-1:0] vh_q, vh_d;

   logic [CHANNELS*SKEW_W-1:0] skew_q, skew_d;
   logic [CHANNELS-1:0]        hit;
   logic [CHANNELS-1:0]        out_vld;
   logic [CHANNELS-1:0]        out_pat;

   // Shared valid pipeline and valid history shift
   always_comb begin
      pv_d    = pv_q;
      vh_d    = vh_q;
      pv_d[0] = bus.din_valid;
      for (int j = 1; j < STAGES; j++) pv_d[j] = pv_q[j-1];
      vh_d[0] = pv_q[STAGES-1];
      for (int j = 1; j < MAX_SKEW; j++) vh_d[j] = vh_q[j-1];
   end

   // Valid registers shift every clock
   always_ff @(posedge clk) begin
      if (reset) begin
         pv_q <= '0;
         vh_q <= '0;
      end else begin
         pv_q <= pv_d;
         vh_q <= vh_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
         logic [WIDTH-1:0]  pipe_q [STAGES];
         logic [WIDTH-1:0]  pipe_d [STAGES];
         logic [WIDTH-1:0]  hist_q [MAX_SKEW];
         logic [WIDTH-1:0]  hist_d [MAX_SKEW];
         logic [SKEW_W-1:0] lane_skew;
         logic [WIDTH-1:0]  lane_out;
         logic              lane_vld;

         // Fixed stages feed the deskew history line
         always_comb begin
            pipe_d    = pipe_q;
            hist_d    = hist_q;
            pipe_d[0] = bus.din[gi*WIDTH +: WIDTH];
            for (int j = 1; j < STAGES; j++) pipe_d[j] = pipe_q[j-1];
            hist_d[0] = pipe_q[STAGES-1];
            for (int j = 1; j < MAX_SKEW; j++) hist_d[j] = hist_q[j-1];
         end

         // Lane data registers shift every clock regardless of valid
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int j = 0; j < STAGES; j++) pipe_q[j] <= '0;
               for (int j = 0; j < MAX_SKEW; j++) hist_q[j] <= '0;
            end else begin
               pipe_q <= pipe_d;
               hist_q <= hist_d;
            end
         end

         assign lane_skew = skew_q[gi*SKEW_W +: SKEW_W];

         // Tap select: skew 0 is the stage output, skew j is j cycles later
         always_comb begin
            lane_out = pipe_q[STAGES-1];
            lane_vld = pv_q[STAGES-1];
            for (int j = 1; j <= MAX_SKEW; j++) begin
               if (lane_skew == SKEW_W'(j)) begin
                  lane_out = hist_q[j-1];
                  lane_vld = vh_q[j-1];
               end
            end
         end

         assign hit[gi]     = pv_q[STAGES-1] && (pipe_q[STAGES-1] == TRAIN_PATTERN);
         assign out_vld[gi] = lane_vld;
         assign out_pat[gi] = (lane_out == TRAIN_PATTERN);
         assign bus.dout[gi*WIDTH +: WIDTH] = lane_out;
      end
   endgenerate

   // Training state
   state_t                           state_q, state_d;
   logic [CHANNELS-1:0]              seen_q, seen_d;
   logic [CHANNELS-1:0][SKEW_W-1:0]  arr_q, arr_d;
   logic [T_W-1:0]                   t_q, t_d;
   logic                             t_run_q, t_run_d;
   logic [TIMER_W-1:0]               timer_q, timer_d;
   logic [MATCH_W-1:0]               match_q, match_d;
   logic [FLUSH_W-1:0]               flush_q, flush_d;

   logic [T_W-1:0]      cur_t;
   logic [CHANNELS-1:0] new_seen;
   logic [SKEW_W-1:0]   arr_max;
   logic                marker_ev;
   logic                marker_ok;

   assign marker_ev = |(out_vld & out_pat);
   assign marker_ok = &(out_vld & out_pat);

   // Next-state logic for SEARCH/VERIFY and skew programming
   always_comb begin
      state_d  = state_q;
      seen_d   = seen_q;
      arr_d    = arr_q;
      t_d      = t_q;
      t_run_d  = t_run_q;
      timer_d  = timer_q;
      match_d  = match_q;
      flush_d  = flush_q;
      skew_d   = skew_q;
      cur_t    = t_run_q ? t_q : '0;
      new_seen = seen_q | hit;
      arr_max  = '0;

      case (state_q)
         ST_SEARCH: begin
            // Arrival window exceeded with a lane still missing, or no
            // complete set of markers within the timeout
            if ((t_run_q && (t_q > T_LIMIT)) || (timer_q == TIMER_LAST)) begin
               state_d = ST_FAIL;
            end else begin
               timer_d = timer_q + 1'b1;
               for (int i = 0; i < CHANNELS; i++) begin
                  if (hit[i] && !seen_q[i]) arr_d[i] = cur_t[SKEW_W-1:0];
               end
               seen_d = new_seen;
               if (t_run_q || (|hit)) begin
                  t_run_d = 1'b1;
                  t_d     = cur_t + 1'b1;
               end
               if (&new_seen) begin
                  for (int i = 0; i < CHANNELS; i++) begin
                     if (arr_d[i] > arr_max) arr_max = arr_d[i];
                  end
                  for (int i = 0; i < CHANNELS; i++) begin
                     skew_d[i*SKEW_W +: SKEW_W] = arr_max - arr_d[i];
                  end
                  state_d = ST_VERIFY;
                  timer_d = '0;
                  match_d = '0;
                  flush_d = '0;
               end
            end
         end
         ST_VERIFY: begin
            timer_d = timer_q + 1'b1;
            if (flush_q != FLUSH_LAST) begin
               // Delay lines still hold data from before the new skews
               flush_d = flush_q + 1'b1;
               if (timer_q == TIMER_LAST) state_d = ST_FAIL;
            end else if (marker_ev) begin
               timer_d = '0;
               if (!marker_ok) begin
                  state_d = ST_FAIL;
               end else if (match_q == MATCH_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  match_d = match_q + 1'b1;
               end
            end else if (timer_q == TIMER_LAST) begin
               state_d = ST_FAIL;
            end
         end
         default: ;
      endcase

      // A training request restarts from any state; skews are kept until
      // the new search completes
      if (bus.train_start) begin
         state_d = ST_SEARCH;
         seen_d  = '0;
         arr_d   = '0;
         t_d     = '0;
         t_run_d = 1'b0;
         timer_d = '0;
         match_d = '0;
         flush_d = '0;
      end
   end

   // Training registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         seen_q  <= '0;
         arr_q   <= '0;
         t_q     <= '0;
         t_run_q <= 1'b0;
         timer_q <= '0;
         match_q <= '0;
         flush_q <= '0;
         skew_q  <= '0;
      end else begin
         state_q <= state_d;
         seen_q  <= seen_d;
         arr_q   <= arr_d;
         t_q     <= t_d;
         t_run_q <= t_run_d;
         timer_q <= timer_d;
         match_q <= match_d;
         flush_q <= flush_d;
         skew_q  <= skew_d;
      end
   end

   assign bus.dout_valid = pv_q[STAGES-1];
   assign bus.skew       = skew_q;
   assign bus.train_busy = (state_q == ST_SEARCH) || (state_q == ST_VERIFY);
   assign bus.aligned    = (state_q == ST_DONE);
   assign bus.train_fail = (state_q == ST_FAIL);
endmodule
